// File: rtl/rr_arbiter8.sv
// Eight-input round-robin arbiter with registered one-hot grant and a grant-hold timeout.
// Feeds the 8-to-3 encoder directly, so grant is guaranteed never to be multi-hot.
module rr_arbiter8 #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       en,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic       timeout_pulse
);

    localparam int                CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_grant;
    logic             r_tpulse;

    state_t           w_state_nx;
    logic [2:0]       w_ptr_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [7:0]       w_grant_nx;
    logic             w_tpulse_nx;
    logic [3:0]       w_srch_all;
    logic [3:0]       w_srch_oth;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_expired;

    // Circular first-set search starting at 'start'; returns {hit, index}.
    function automatic logic [3:0] f_search(input logic [7:0] mask, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (mask[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [7:0] f_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= 3'd7;
            r_cnt    <= '0;
            r_grant  <= 8'h00;
            r_tpulse <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ptr    <= w_ptr_nx;
            r_cnt    <= w_cnt_nx;
            r_grant  <= w_grant_nx;
            r_tpulse <= w_tpulse_nx;
        end
    end

    // In GRANT r_ptr is the current holder, so masking it excludes the holder from the rotation.
    assign w_srch_all = f_search(req, r_ptr + 3'd1);
    assign w_srch_oth = f_search(req & ~f_onehot(r_ptr), r_ptr + 3'd1);
    assign w_cnt_inc  = (TIMEOUT != 0 && r_cnt != CNT_MAX) ? r_cnt + CNT_ONE : r_cnt;
    assign w_expired  = (TIMEOUT != 0) && (r_cnt == CNT_MAX);

    always_comb begin
        w_state_nx  = r_state;
        w_ptr_nx    = r_ptr;
        w_cnt_nx    = r_cnt;
        w_grant_nx  = r_grant;
        w_tpulse_nx = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant_nx = 8'h00;
                w_cnt_nx   = '0;
                if (en && w_srch_all[3]) begin
                    w_state_nx = GRANT;
                    w_ptr_nx   = w_srch_all[2:0];
                    w_grant_nx = f_onehot(w_srch_all[2:0]);
                    w_cnt_nx   = CNT_ONE;
                end
            end
            GRANT: begin
                if (!en) begin
                    w_state_nx = IDLE;
                    w_grant_nx = 8'h00;
                    w_cnt_nx   = '0;
                end else if (!req[r_ptr]) begin
                    if (w_srch_oth[3]) begin
                        w_ptr_nx   = w_srch_oth[2:0];
                        w_grant_nx = f_onehot(w_srch_oth[2:0]);
                        w_cnt_nx   = CNT_ONE;
                    end else begin
                        w_state_nx = IDLE;
                        w_grant_nx = 8'h00;
                        w_cnt_nx   = '0;
                    end
                end else if (w_expired) begin
                    w_tpulse_nx = 1'b1;
                    w_cnt_nx    = CNT_ONE;
                    if (w_srch_oth[3]) begin
                        w_ptr_nx   = w_srch_oth[2:0];
                        w_grant_nx = f_onehot(w_srch_oth[2:0]);
                    end
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_grant_nx = 8'h00;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        grant         = r_grant;
        grant_valid   = |r_grant;
        timeout_pulse = r_tpulse;
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (TIMEOUT=4): directed scenarios plus a random run
// checked through an inline 8-to-3 encoder model.
module tb_rr_arbiter8;

    localparam int TO = 4;

    typedef struct packed {
        logic [7:0] g;
        logic       tp;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       en;
    logic [7:0] grant;
    logic       grant_valid;
    logic       timeout_pulse;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    logic       m_busy;
    logic [2:0] m_ptr;
    int         m_cnt;

    rr_arbiter8 #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .en           (en),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    function automatic logic [2:0] pick(input logic [7:0] m, input logic [2:0] last);
        logic [2:0] idx;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (m[idx]) return idx;
        end
        return last;
    endfunction

    // Encoder model: {valid, index of hot bit}
    function automatic logic [3:0] enc8(input logic [7:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int k = 0; k < 8; k++)
            if (v[k]) r = {1'b1, 3'(k)};
        return r;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic e,
                              output logic [7:0] eg, output logic etp);
        logic [7:0] others;
        etp    = 1'b0;
        others = r & ~(8'h01 << m_ptr);
        if (!m_busy) begin
            if (e && r != 8'h00) begin
                m_ptr  = pick(r, m_ptr);
                m_busy = 1'b1;
                m_cnt  = 1;
            end
        end else if (!e) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (!r[m_ptr]) begin
            if (others != 8'h00) begin
                m_ptr = pick(others, m_ptr);
                m_cnt = 1;
            end else begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end
        end else if (m_cnt == TO) begin
            etp = 1'b1;
            if (others != 8'h00) m_ptr = pick(others, m_ptr);
            m_cnt = 1;
        end else begin
            m_cnt = m_cnt + 1;
        end
        eg = m_busy ? (8'h01 << m_ptr) : 8'h00;
    endtask

    task automatic step(input logic [7:0] r, input logic e, input logic [7:0] eg, input logic etp);
        req = r;
        en  = e;
        sb.push_back('{g: eg, tp: etp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.delete();
        m_busy = 1'b0;
        m_ptr  = 3'd7;
        m_cnt  = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        req   = 8'h00;
        en    = 1'b0;
        #1;
        e = '{g: 8'h00, tp: 1'b0};
        n_checks++;
        if (grant !== e.g || grant_valid !== 1'b0 || timeout_pulse !== e.tp) begin
            n_errors++;
            $display("FAIL reset: grant=%h valid=%b pulse=%b, expected 00/0/0", grant, grant_valid, timeout_pulse);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single();
        exp_t       e;
        logic [7:0] rq [2] = '{8'h04, 8'h00};
        logic [7:0] eg [2] = '{8'h04, 8'h00};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(rq[i], 1'b1, eg[i], 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g || grant_valid !== (e.g != 8'h00) || timeout_pulse !== e.tp) begin
                n_errors++;
                $display("FAIL single[%0d]: grant=%h valid=%b pulse=%b, expected %h/%b/%b",
                         i, grant, grant_valid, timeout_pulse, e.g, e.g != 8'h00, e.tp);
            end
        end
    endtask

    task automatic test_fairness();
        exp_t       e;
        logic [7:0] rq [10] = '{8'h81, 8'h81, 8'h81, 8'h80, 8'h81, 8'h81, 8'h01, 8'h81, 8'h81, 8'h80};
        logic [7:0] eg [10] = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01, 8'h80};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(rq[i], 1'b1, eg[i], 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g || grant_valid !== (e.g != 8'h00) || timeout_pulse !== e.tp) begin
                n_errors++;
                $display("FAIL fairness[%0d]: grant=%h valid=%b pulse=%b, expected %h/%b/%b",
                         i, grant, grant_valid, timeout_pulse, e.g, e.g != 8'h00, e.tp);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t       e;
        logic [7:0] rq [3] = '{8'h40, 8'h00, 8'h41};
        logic [7:0] eg [3] = '{8'h40, 8'h00, 8'h01};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(rq[i], 1'b1, eg[i], 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g || grant_valid !== (e.g != 8'h00) || timeout_pulse !== e.tp) begin
                n_errors++;
                $display("FAIL wrap[%0d]: grant=%h valid=%b pulse=%b, expected %h/%b/%b",
                         i, grant, grant_valid, timeout_pulse, e.g, e.g != 8'h00, e.tp);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t       e;
        logic [7:0] rq [22] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03,
                                8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
                                8'h10, 8'h10, 8'h10, 8'h20};
        logic [7:0] eg [22] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01,
                                8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
                                8'h10, 8'h10, 8'h10, 8'h20};
        logic       tp [22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(rq[i], 1'b1, eg[i], tp[i]);
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g || grant_valid !== (e.g != 8'h00) || timeout_pulse !== e.tp) begin
                n_errors++;
                $display("FAIL timeout[%0d]: grant=%h valid=%b pulse=%b, expected %h/%b/%b",
                         i, grant, grant_valid, timeout_pulse, e.g, e.g != 8'h00, e.tp);
            end
        end
    endtask

    task automatic test_enable();
        exp_t       e;
        logic [7:0] rq [6] = '{8'h08, 8'h08, 8'hFF, 8'hFF, 8'h20, 8'hFF};
        logic       en_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] eg [6] = '{8'h08, 8'h00, 8'h00, 8'h10, 8'h00, 8'h20};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(rq[i], en_v[i], eg[i], 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g || grant_valid !== (e.g != 8'h00) || timeout_pulse !== e.tp) begin
                n_errors++;
                $display("FAIL enable[%0d]: grant=%h valid=%b pulse=%b, expected %h/%b/%b",
                         i, grant, grant_valid, timeout_pulse, e.g, e.g != 8'h00, e.tp);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [7:0] rq [2] = '{8'h04, 8'hFF};
        logic [7:0] eg [2] = '{8'h04, 8'h04};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(rq[i], 1'b1, eg[i], 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (grant !== e.g || grant_valid !== (e.g != 8'h00)) begin
                n_errors++;
                $display("FAIL reset_mid_pre[%0d]: grant=%h valid=%b, expected %h/%b",
                         i, grant, grant_valid, e.g, e.g != 8'h00);
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || timeout_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_async: grant=%h valid=%b pulse=%b, expected 00/0/0",
                     grant, grant_valid, timeout_pulse);
        end
        do_reset();
        step(8'hFF, 1'b1, 8'h01, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (grant !== e.g || grant_valid !== 1'b1 || timeout_pulse !== e.tp) begin
            n_errors++;
            $display("FAIL reset_mid_restart: grant=%h valid=%b pulse=%b, expected %h/1/%b",
                     grant, grant_valid, timeout_pulse, e.g, e.tp);
        end
    endtask

    task automatic test_encoder_random();
        exp_t       e;
        logic [7:0] r;
        logic       en_r;
        logic [7:0] eg;
        logic       etp;
        logic [3:0] enc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom) & 8'($urandom);
            en_r = ($urandom_range(0, 9) != 0);
            model_step(r, en_r, eg, etp);
            step(r, en_r, eg, etp);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL encoder[%0d]: scoreboard empty, expected one entry", i);
            end else begin
                e   = sb.pop_front();
                enc = enc8(grant);
                n_checks++;
                if (grant !== e.g || timeout_pulse !== e.tp || $countones(grant) > 1 ||
                    enc[3] !== grant_valid || enc[3] !== (e.g != 8'h00) ||
                    (e.g != 8'h00 && enc[2:0] !== m_ptr)) begin
                    n_errors++;
                    $display("FAIL encoder[%0d]: grant=%h valid=%b pulse=%b enc=%0d/%b, expected %h/%b idx=%0d",
                             i, grant, grant_valid, timeout_pulse, enc[2:0], enc[3], e.g, e.tp, m_ptr);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = 8'h00;
        en       = 1'b0;
        m_busy   = 1'b0;
        m_ptr    = 3'd7;
        m_cnt    = 0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_encoder_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
